pipe_stall_ctrl: RTL and testbench

//  Parametrised pipeline hold/bubble/flush controller for an N-stage in-order pipe.

---
 rtl/pipe_stall_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - per-stage hold/bubble/flush controller with init window and stall watchdog
// Optional stall_cycles perf counter is enabled by defining STALL_PERF_EN.
module pipe_stall_ctrl #(
  parameter int N_STAGES    = 5,
  parameter int INIT_CYCLES = 16,
  parameter int TIMEOUT_W   = 8,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_STAGES-1:0] stall_req,
  input  logic [N_STAGES-1:0] flush_req,
  input  logic                timeout_clr,
  output logic [N_STAGES-1:0] hold,
  output logic [N_STAGES-1:0] bubble,
  output logic [N_STAGES-1:0] flush,
  output logic                init_busy,
  output logic                timeout,
  output logic [CNT_W-1:0]    stall_cycles
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_ERR} state_t;

  localparam int ICW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
  localparam logic [ICW-1:0] INIT_LAST = ICW'((INIT_CYCLES == 0) ? 0 : INIT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;
  // With no init window the 0th cycle after reset is already a RUN cycle.
  localparam state_t RST_STATE = (INIT_CYCLES == 0) ? S_RUN : S_INIT;

  state_t                state, state_n;
  logic [ICW-1:0]        init_cnt;
  logic [TIMEOUT_W-1:0]  wd;
  logic [N_STAGES-1:0]   pend, pend_n, req_m, eff, hold_run, flush_run;
  logic                  stall_acc, flush_acc;

  always_comb begin
    req_m     = flush_req & ~{{(N_STAGES-1){1'b0}}, 1'b1};
    stall_acc = 1'b0;
    flush_acc = 1'b0;
    hold_run  = '0;
    flush_run = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      stall_acc   = stall_acc | stall_req[i];
      hold_run[i] = stall_acc;
    end
    eff = (req_m | pend) & ~hold_run;
    // A stage is flushed by any firing requester older than itself, unless it is held.
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      flush_run[i] = flush_acc & ~hold_run[i];
      flush_acc    = flush_acc | eff[i];
    end
    pend_n = (pend | (req_m & hold_run)) & ~eff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_STATE;
      init_cnt <= '0;
      wd       <= '0;
      pend     <= '0;
    end else begin
      state <= state_n;
      if (state == S_INIT) init_cnt <= init_cnt + ICW'(1);
      if (state == S_RUN && hold_run[0])
        wd <= (wd == WD_MAX) ? wd : wd + TIMEOUT_W'(1);
      else
        wd <= '0;
      pend <= (state == S_RUN) ? pend_n : '0;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_INIT:  if (init_cnt == INIT_LAST) state_n = S_RUN;
      S_RUN:   if (wd == WD_MAX) state_n = S_ERR;
      S_ERR:   if (timeout_clr) state_n = S_RUN;
      default: state_n = S_INIT;
    endcase
  end

  always_comb begin
    hold      = '1;
    bubble    = '0;
    flush     = '0;
    init_busy = 1'b0;
    timeout   = 1'b0;
    if (rst) begin
      init_busy = 1'b1;
    end else begin
      case (state)
        S_INIT: init_busy = 1'b1;
        S_RUN: begin
          hold   = hold_run;
          bubble = {hold_run[N_STAGES-2:0] & ~hold_run[N_STAGES-1:1], 1'b0};
          flush  = flush_run;
        end
        S_ERR:   timeout = 1'b1;
        default: init_busy = 1'b1;
      endcase
    end
  end

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      perf_cnt <= '0;
    else if (state == S_RUN && hold_run[0])
      perf_cnt <= perf_cnt + CNT_W'(1);
  end

  assign stall_cycles = perf_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed and randomized checks of pipe_stall_ctrl against a behavioural model
module tb_pipe_stall_ctrl;
  localparam int N  = 5;
  localparam int IC = 4;
  localparam int TW = 4;
  localparam int CW = 32;
  localparam int WD_LIMIT = (1 << TW) - 1;
`ifdef STALL_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  localparam int M_INIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_ERR  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  stall_req = '0;
  logic [N-1:0]  flush_req = '0;
  logic          timeout_clr = 1'b0;
  logic [N-1:0]  hold, bubble, flush;
  logic          init_busy, timeout;
  logic [CW-1:0] stall_cycles;

  int n_checks = 0;
  int n_err    = 0;

  int          m_mode;
  int          m_init_seen;
  int          m_wd;
  logic [N-1:0] m_pend;
  int unsigned m_perf;
  logic [N-1:0] e_hold, e_bub, e_flush, e_eff;
  logic         e_busy, e_to;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.N_STAGES(N), .INIT_CYCLES(IC), .TIMEOUT_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .timeout_clr(timeout_clr), .hold(hold), .bubble(bubble), .flush(flush),
    .init_busy(init_busy), .timeout(timeout), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_out();
    int hi;
    e_hold = '1; e_bub = '0; e_flush = '0; e_eff = '0;
    e_busy = rst || (m_mode == M_INIT);
    e_to   = !rst && (m_mode == M_ERR);
    if (!rst && m_mode == M_RUN) begin
      hi = -1;
      for (int i = 0; i < N; i++) if (stall_req[i]) hi = i;
      for (int i = 0; i < N; i++) e_hold[i] = (i <= hi);
      for (int i = 1; i < N; i++) e_bub[i] = e_hold[i-1] && !e_hold[i];
      for (int k = 1; k < N; k++) e_eff[k] = (flush_req[k] || m_pend[k]) && !e_hold[k];
      for (int i = 0; i < N; i++)
        for (int k = i + 1; k < N; k++)
          if (e_eff[k] && !e_hold[i]) e_flush[i] = 1'b1;
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] s, input logic [N-1:0] f, input logic c);
    rst = r; stall_req = s; flush_req = f; timeout_clr = c;
    @(negedge clk);
    model_out();
    chk("hold", 32'(hold), 32'(e_hold));
    chk("bubble", 32'(bubble), 32'(e_bub));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("init_busy", 32'(init_busy), 32'(e_busy));
    chk("timeout", 32'(timeout), 32'(e_to));
    chk("stall_cycles", stall_cycles, PERF_EN ? m_perf : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_mode = (IC == 0) ? M_RUN : M_INIT;
      m_init_seen = 0; m_wd = 0; m_pend = '0; m_perf = 0;
    end else if (m_mode == M_INIT) begin
      m_init_seen++;
      if (m_init_seen == IC) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (|stall_req) m_perf++;
      if (m_wd == WD_LIMIT) begin
        m_mode = M_ERR; m_wd = 0; m_pend = '0;
      end else begin
        m_wd = (|stall_req) ? m_wd + 1 : 0;
        m_pend = (m_pend | (flush_req & e_hold & ~N'(1))) & ~e_eff;
      end
    end else if (timeout_clr) begin
      m_mode = M_RUN;
    end
    #1;
  endtask

  initial begin
    m_mode = M_INIT; m_init_seen = 0; m_wd = 0; m_pend = '0; m_perf = 0;
    #1;
    drive(1, 0, 0, 0); tick();
    drive(1, 0, 0, 0);
    chk("rst_hold", 32'(hold), 32'h1f);
    chk("rst_busy", 32'(init_busy), 32'd1);
    tick();
    for (int i = 0; i < IC; i++) begin
      drive(0, 0, 0, 0);
      chk("init_hold", 32'(hold), 32'h1f);
      tick();
    end
    drive(0, 0, 0, 0);
    chk("run_hold", 32'(hold), 32'h0);
    chk("run_busy", 32'(init_busy), 32'd0);
    tick();

    drive(0, 5'b01000, 0, 0);
    chk("stall_hold", 32'(hold), 32'b01111);
    chk("stall_bubble", 32'(bubble), 32'b10000);
    tick();
    drive(0, 0, 0, 0);
    chk("unstall_hold", 32'(hold), 32'h0);
    tick();

    drive(0, 0, 5'b00100, 0);
    chk("flush_now", 32'(flush), 32'b00011);
    tick();

    drive(0, 5'b00100, 5'b00100, 0);
    chk("pend_c1_flush", 32'(flush), 32'h0);
    chk("pend_c1_hold", 32'(hold), 32'b00111);
    tick();
    drive(0, 0, 0, 0);
    chk("pend_c2_flush", 32'(flush), 32'b00011);
    tick();
    drive(0, 0, 0, 0);
    chk("pend_c3_flush", 32'(flush), 32'h0);
    tick();

    for (int i = 1; i <= WD_LIMIT + 2; i++) begin
      drive(0, 5'b00001, 0, 0);
      chk("wd_timeout", 32'(timeout), (i > WD_LIMIT + 1) ? 32'd1 : 32'd0);
      tick();
    end
    drive(0, 0, 0, 1);
    chk("err_hold", 32'(hold), 32'h1f);
    tick();
    drive(0, 0, 0, 0);
    chk("clr_timeout", 32'(timeout), 32'd0);
    chk("clr_hold", 32'(hold), 32'h0);
    tick();

    for (int n = 0; n < 500; n++) begin
      logic [N-1:0] s, f;
      s = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      f = ($urandom_range(0, 1) == 0) ? N'($urandom) : '0;
      drive($urandom_range(0, 99) == 0, s, f, $urandom_range(0, 3) == 0);
      tick();
    end

    drive(1, 0, 0, 0); tick();
    for (int i = 0; i < IC; i++) begin drive(0, 0, 0, 0); tick(); end
    for (int i = 0; i < 7; i++) begin drive(0, 5'b00010, 0, 0); tick(); end
    drive(0, 0, 0, 0);
    chk("perf_7", stall_cycles, PERF_EN ? 32'd7 : 32'd0);
    tick();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    chk("perf_rst", stall_cycles, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
